// File: rtl/usb_pulpino_mailbox_if.sv
// Mailbox bus between the USB register block / PULPino GPIO and the mailbox core.
// slave  : mailbox side (takes data and toggles, returns FIFO status)
// master : sender/receiver side
interface usb_pulpino_mailbox_if #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pDEPTH      = 16
);
    localparam int unsigned pCNT_WIDTH = $clog2(pDEPTH) + 1;

    logic                   clear_i;

    logic [pDATA_WIDTH-1:0] u2p_wdata_i;
    logic                   u2p_wtoggle_i;
    logic                   u2p_rtoggle_i;
    logic [pDATA_WIDTH-1:0] u2p_rdata_o;
    logic                   u2p_valid_o;
    logic                   u2p_full_o;
    logic [pCNT_WIDTH-1:0]  u2p_count_o;

    logic [pDATA_WIDTH-1:0] p2u_wdata_i;
    logic                   p2u_wtoggle_i;
    logic                   p2u_rtoggle_i;
    logic [pDATA_WIDTH-1:0] p2u_rdata_o;
    logic                   p2u_valid_o;
    logic                   p2u_full_o;
    logic [pCNT_WIDTH-1:0]  p2u_count_o;

    logic [1:0]             overflow_o;
    logic [1:0]             underflow_o;
    logic                   irq_o;

    modport slave (
        input  clear_i,
        input  u2p_wdata_i, u2p_wtoggle_i, u2p_rtoggle_i,
        output u2p_rdata_o, u2p_valid_o, u2p_full_o, u2p_count_o,
        input  p2u_wdata_i, p2u_wtoggle_i, p2u_rtoggle_i,
        output p2u_rdata_o, p2u_valid_o, p2u_full_o, p2u_count_o,
        output overflow_o, underflow_o, irq_o
    );

    modport master (
        output clear_i,
        output u2p_wdata_i, u2p_wtoggle_i, u2p_rtoggle_i,
        input  u2p_rdata_o, u2p_valid_o, u2p_full_o, u2p_count_o,
        output p2u_wdata_i, p2u_wtoggle_i, p2u_rtoggle_i,
        input  p2u_rdata_o, p2u_valid_o, p2u_full_o, p2u_count_o,
        input  overflow_o, underflow_o, irq_o
    );
endinterface

// File: rtl/usb_pulpino_mailbox.sv
// Bidirectional toggle-handshake FIFO mailbox between USB registers and PULPino GPIO.
// Index 0 = USB->PULPino (u2p), index 1 = PULPino->USB (p2u); the directions never interact.
// Optional feature macro: MAILBOX_IRQ_EN (enables irq_o; otherwise irq_o is held at 0).
module usb_pulpino_mailbox #(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pDEPTH      = 16,
    parameter int unsigned pIRQ_THRESH = 1
) (
    input  logic                   clk,
    input  logic                   reset_i,
    usb_pulpino_mailbox_if.slave   bus
);
    localparam int unsigned pCNT_WIDTH = $clog2(pDEPTH) + 1;
    localparam int unsigned PTR_W      = $clog2(pDEPTH);
    localparam int unsigned NDIR       = 2;

`ifdef MAILBOX_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic [NDIR-1:0]        wtog_i, rtog_i;
    logic [pDATA_WIDTH-1:0] wdata_i [NDIR];

    logic [NDIR-1:0]        wtog_q, rtog_q;
    logic [PTR_W-1:0]       wptr_q [NDIR];
    logic [PTR_W-1:0]       wptr_d [NDIR];
    logic [PTR_W-1:0]       rptr_q [NDIR];
    logic [PTR_W-1:0]       rptr_d [NDIR];
    logic [pCNT_WIDTH-1:0]  cnt_q  [NDIR];
    logic [pCNT_WIDTH-1:0]  cnt_d  [NDIR];
    logic [NDIR-1:0]        ovf_q, ovf_d;
    logic [NDIR-1:0]        unf_q, unf_d;
    logic                   irq_q, irq_d;
    logic [pDATA_WIDTH-1:0] mem_q  [NDIR][pDEPTH];

    logic [NDIR-1:0]        wev, rev, empty, full, push, pop;

    assign wtog_i     = {bus.p2u_wtoggle_i, bus.u2p_wtoggle_i};
    assign rtog_i     = {bus.p2u_rtoggle_i, bus.u2p_rtoggle_i};
    assign wdata_i[0] = bus.u2p_wdata_i;
    assign wdata_i[1] = bus.p2u_wdata_i;

    // Level change on a toggle input is one event; clear suppresses all events.
    assign wev = (wtog_i ^ wtog_q) & {NDIR{~bus.clear_i}};
    assign rev = (rtog_i ^ rtog_q) & {NDIR{~bus.clear_i}};

    // Occupancy flags per direction
    always_comb begin
        empty = '0;
        full  = '0;
        for (int d = 0; d < int'(NDIR); d++) begin
            empty[d] = (cnt_q[d] == '0);
            full[d]  = (cnt_q[d] == pCNT_WIDTH'(pDEPTH));
        end
    end

    // Accepted push/pop: a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        pop  = rev & ~empty;
        push = wev & (~full | pop);
    end

    // Next-state for pointers, counts, stickies and interrupt
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        for (int d = 0; d < int'(NDIR); d++) begin
            if (bus.clear_i) begin
                wptr_d[d] = '0;
                rptr_d[d] = '0;
                cnt_d[d]  = '0;
                ovf_d[d]  = 1'b0;
                unf_d[d]  = 1'b0;
            end else begin
                wptr_d[d] = wptr_q[d] + PTR_W'(push[d]);
                rptr_d[d] = rptr_q[d] + PTR_W'(pop[d]);
                cnt_d[d]  = cnt_q[d] + pCNT_WIDTH'(push[d]) - pCNT_WIDTH'(pop[d]);
                if (wev[d] && !push[d]) ovf_d[d] = 1'b1;
                if (rev[d] && empty[d]) unf_d[d] = 1'b1;
            end
        end
        irq_d = IRQ_EN & ((cnt_q[0] >= pCNT_WIDTH'(pIRQ_THRESH)) | ovf_q[0] | unf_q[1]);
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wtog_q <= '0;
            rtog_q <= '0;
            ovf_q  <= '0;
            unf_q  <= '0;
            irq_q  <= 1'b0;
            for (int d = 0; d < int'(NDIR); d++) begin
                wptr_q[d] <= '0;
                rptr_q[d] <= '0;
                cnt_q[d]  <= '0;
            end
        end else begin
            wtog_q <= wtog_i;
            rtog_q <= rtog_i;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            irq_q  <= irq_d;
            for (int d = 0; d < int'(NDIR); d++) begin
                wptr_q[d] <= wptr_d[d];
                rptr_q[d] <= rptr_d[d];
                cnt_q[d]  <= cnt_d[d];
            end
        end
    end

    // FIFO storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        for (int d = 0; d < int'(NDIR); d++) begin
            if (push[d]) mem_q[d][wptr_q[d]] <= wdata_i[d];
        end
    end

    assign bus.u2p_valid_o = ~empty[0];
    assign bus.u2p_full_o  = full[0];
    assign bus.u2p_count_o = cnt_q[0];
    assign bus.u2p_rdata_o = empty[0] ? '0 : mem_q[0][rptr_q[0]];

    assign bus.p2u_valid_o = ~empty[1];
    assign bus.p2u_full_o  = full[1];
    assign bus.p2u_count_o = cnt_q[1];
    assign bus.p2u_rdata_o = empty[1] ? '0 : mem_q[1][rptr_q[1]];

    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
    assign bus.irq_o       = irq_q;
endmodule
